// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a byte-banked memory: one request at a time,
// lane steering and byte enables for stores, extraction and extension for loads.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_AMOUNT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_we,
  output logic                  mem_rd,
  output logic [RAM_AMOUNT-1:0] mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_dout_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RDATA  = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  localparam int LANES = DATA_WIDTH / 8;

  function automatic logic req_bad(input logic store, input logic [2:0] f3,
                                   input logic [1:0] lo);
    logic illegal;
    logic misaligned;
    if (store) illegal = (f3 > 3'b010);
    else       illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) ||
                 ((f3[1:0] == 2'b10) && (lo != 2'b00));
    return illegal || misaligned;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] store_lanes(input logic [1:0] f3,
                                                        input logic [DATA_WIDTH-1:0] wd);
    case (f3)
      2'b00:   return {LANES{wd[7:0]}};
      2'b01:   return {(LANES/2){wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] f3, input logic [1:0] lo);
    case (f3)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extract(input logic [2:0] f3,
                                                         input logic [1:0] lo,
                                                         input logic [DATA_WIDTH-1:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[16 +: 16] : word[0 +: 16];
    case (f3)
      3'b000:  return DATA_WIDTH'(b);
      3'b001:  return DATA_WIDTH'(h);
      3'b100:  return DATA_WIDTH'($unsigned(b));
      3'b101:  return DATA_WIDTH'($unsigned(h));
      default: return word;
    endcase
  endfunction

  logic [1:0] state;
  logic       store_p0;
  logic [2:0] funct3_p0;
  logic [1:0] addr_lo_p0;
  logic       bad;
  logic       in_access;

  assign bad = req_bad(req_store, req_funct3, req_addr[1:0]);

  // Stage p0: request capture on acceptance
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      store_p0   <= req_store;
      funct3_p0  <= req_funct3;
      addr_lo_p0 <= req_addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_di     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            resp_rdata <= '0;
            resp_err   <= bad;
            if (!bad) begin
              mem_addr <= {req_addr[DATA_WIDTH-1:2], 2'b00};
              if (req_store) mem_di <= store_lanes(req_funct3[1:0], req_wdata);
            end
            state <= bad ? RESP : ACCESS;
          end
        end
        ACCESS: state <= store_p0 ? RESP : RDATA;
        RDATA: begin
          if (mem_dout_ready) begin
            resp_rdata <= load_extract(funct3_p0, addr_lo_p0, mem_dout);
            state      <= RESP;
          end
        end
        RESP: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by rst so an aborted store never reaches the banks
  assign in_access  = (state == ACCESS) && !rst;
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP) && !rst;
  assign mem_we     = in_access && store_p0;
  assign mem_rd     = in_access && !store_p0;
  assign mem_ctrl   = in_access
                      ? RAM_AMOUNT'(store_p0 ? byte_enables(funct3_p0[1:0], addr_lo_p0) : 4'b1111)
                      : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-banked memory model and an
// expected-response queue.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic        mem_rd;
  logic [3:0]  mem_ctrl;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_dout;
  logic        mem_dout_ready = 1'b1;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .RAM_AMOUNT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_ctrl(mem_ctrl),
    .mem_addr(mem_addr), .mem_di(mem_di),
    .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready)
  );

  // Byte-banked memory: per-lane write enables, registered read port
  logic [31:0] mem [0:255] = '{default: 32'h0};
  logic [31:0] dout_q = '0;
  assign mem_dout = dout_q;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = di[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_di, mem_ctrl);
    if (mem_rd) dout_q <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic eerr, input logic [31:0] erd, input int elat,
                         input logic [3:0] ectrl, input logic [31:0] edi, input int stall);
    exp_t e;
    exp_t got;
    int cyc;
    int guard;
    logic seen_mem;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "/ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    e.err = eerr; e.rdata = erd; e.lat = elat; e.tag = tag;
    sb_q.push_back(e);
    mem_dout_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    seen_mem = 1'b0;
    while (!resp_valid && cyc < 30) begin
      if (mem_we || mem_rd || mem_ctrl != 4'b0) seen_mem = 1'b1;
      if (cyc == 1 && !eerr) begin
        check({tag, "/we"}, {31'b0, mem_we}, {31'b0, st});
        check({tag, "/rd"}, {31'b0, mem_rd}, {31'b0, ~st});
        check({tag, "/ctrl"}, {28'b0, mem_ctrl}, {28'b0, ectrl});
        check({tag, "/addr"}, mem_addr, {a[31:2], 2'b00});
        if (st) check({tag, "/di"}, mem_di, edi);
      end
      if (stall > 0 && cyc == 2 + stall) mem_dout_ready = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (mem_we || mem_rd || mem_ctrl != 4'b0) seen_mem = 1'b1;
    got = sb_q.pop_front();
    check({got.tag, "/valid"}, {31'b0, resp_valid}, 32'd1);
    check({got.tag, "/latency"}, cyc, got.lat);
    check({got.tag, "/err"}, {31'b0, resp_err}, {31'b0, got.err});
    check({got.tag, "/rdata"}, resp_rdata, got.rdata);
    if (eerr) check({tag, "/mem_quiet"}, {31'b0, seen_mem}, 32'd0);
    @(negedge clk);
    check({tag, "/pulse"}, {31'b0, resp_valid}, 32'd0);
    mem_dout_ready = 1'b1;
  endtask

  initial begin
    logic seen_resp;

    repeat (2) @(negedge clk);
    check("rst/req_ready", {31'b0, req_ready}, 32'd1);
    check("rst/resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst/resp_err", {31'b0, resp_err}, 32'd0);
    check("rst/resp_rdata", resp_rdata, 32'd0);
    check("rst/mem_we", {31'b0, mem_we}, 32'd0);
    check("rst/mem_rd", {31'b0, mem_rd}, 32'd0);
    check("rst/mem_ctrl", {28'b0, mem_ctrl}, 32'd0);
    check("rst/mem_addr", mem_addr, 32'd0);
    check("rst/mem_di", mem_di, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // tag, store, funct3, addr, wdata, err, rdata, latency, ctrl, di, stall
    run_req("sw_100",   1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        2, 4'hF, 32'hDEADBEEF, 0);
    run_req("lw_100",   1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 3, 4'hF, 32'h0,        0);
    run_req("sb_103",   1'b1, 3'b000, 32'h103, 32'h000000A5, 1'b0, 32'h0,        2, 4'h8, 32'hA5A5A5A5, 0);
    run_req("lbu_103",  1'b0, 3'b100, 32'h103, 32'h0,        1'b0, 32'h000000A5, 3, 4'hF, 32'h0,        0);
    run_req("lb_103",   1'b0, 3'b000, 32'h103, 32'h0,        1'b0, 32'hFFFFFFA5, 3, 4'hF, 32'h0,        0);
    run_req("sh_102",   1'b1, 3'b001, 32'h102, 32'h00008001, 1'b0, 32'h0,        2, 4'hC, 32'h80018001, 0);
    run_req("lh_102",   1'b0, 3'b001, 32'h102, 32'h0,        1'b0, 32'hFFFF8001, 3, 4'hF, 32'h0,        0);
    run_req("lhu_102",  1'b0, 3'b101, 32'h102, 32'h0,        1'b0, 32'h00008001, 3, 4'hF, 32'h0,        0);
    run_req("lh_100",   1'b0, 3'b001, 32'h100, 32'h0,        1'b0, 32'hFFFFBEEF, 3, 4'hF, 32'h0,        0);
    run_req("lbu_101",  1'b0, 3'b100, 32'h101, 32'h0,        1'b0, 32'h000000BE, 3, 4'hF, 32'h0,        0);
    run_req("sb_101",   1'b1, 3'b000, 32'h101, 32'h0000117F, 1'b0, 32'h0,        2, 4'h2, 32'h7F7F7F7F, 0);
    run_req("lb_101",   1'b0, 3'b000, 32'h101, 32'h0,        1'b0, 32'h0000007F, 3, 4'hF, 32'h0,        0);
    run_req("lw_100b",  1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'h80017FEF, 3, 4'hF, 32'h0,        0);
    run_req("lw_104",   1'b0, 3'b010, 32'h104, 32'h0,        1'b0, 32'h00000000, 3, 4'hF, 32'h0,        0);
    run_req("err_lw101",1'b0, 3'b010, 32'h101, 32'h0,        1'b1, 32'h0,        1, 4'h0, 32'h0,        0);
    run_req("err_lh003",1'b0, 3'b001, 32'h003, 32'h0,        1'b1, 32'h0,        1, 4'h0, 32'h0,        0);
    run_req("err_st011",1'b1, 3'b011, 32'h100, 32'h12345678, 1'b1, 32'h0,        1, 4'h0, 32'h0,        0);
    run_req("err_ld110",1'b0, 3'b110, 32'h100, 32'h0,        1'b1, 32'h0,        1, 4'h0, 32'h0,        0);
    run_req("sw_restore",1'b1,3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0,        2, 4'hF, 32'hDEADBEEF, 0);
    run_req("lw_stall", 1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'hDEADBEEF, 6, 4'hF, 32'h0,        3);

    // Store aborted by reset during its ACCESS cycle
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort/we_access", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort/we_in_rst", {31'b0, mem_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("abort/req_ready", {31'b0, req_ready}, 32'd1);
    seen_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen_resp = 1'b1;
      @(negedge clk);
    end
    check("abort/no_resp", {31'b0, seen_resp}, 32'd0);
    run_req("lw_after_abort", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0, 32'hDEADBEEF, 3, 4'hF, 32'h0, 0);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter RAM_AMOUNT, default 4, number of byte banks (one mem_ctrl bit each).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  CPU request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept request.
REQ-007 SHALL have port req_store  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-009 SHALL have port req_addr  input  DATA_WIDTH  byte address.
REQ-010 SHALL have port req_wdata  input  DATA_WIDTH  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  DATA_WIDTH  extended load result; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  misaligned or illegal funct3; qualified by resp_valid.
REQ-014 SHALL have ports mem_we (output, 1), mem_rd (output, 1), mem_ctrl (output, RAM_AMOUNT), mem_addr (output, DATA_WIDTH) and mem_di (output, DATA_WIDTH), all driving the byte-banked memory.
REQ-015 SHALL have ports mem_dout (input, DATA_WIDTH) and mem_dout_ready (input, 1), carrying memory read data.

Function
REQ-016 SHALL implement states IDLE, ACCESS, RDATA, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE: on req_valid, SHALL register store, funct3, addr and wdata, then decode.
REQ-017a Illegal or misaligned request -> RESP with resp_err=1 and no memory access; legal request -> ACCESS.
REQ-018 Misaligned SHALL mean: halfword with addr[0]=1, or word with addr[1:0]!=00.
REQ-018a Illegal SHALL mean: loads with funct3 011/110/111; stores with funct3 > 010.
REQ-019 ACCESS (exactly one cycle): mem_addr SHALL = registered addr with bits[1:0] forced to 00.
REQ-020 Store in ACCESS: mem_we=1, mem_rd=0; next state RESP.
REQ-020a Store byte enables: SB mem_ctrl = 1<<addr[1:0], byte replicated to all four lanes of mem_di.
REQ-020b Store byte enables: SH mem_ctrl = addr[1]?1100:0011, halfword replicated to both halves of mem_di.
REQ-020c Store byte enables: SW mem_ctrl = 1111, mem_di = wdata.
REQ-021 Load in ACCESS: mem_rd=1, mem_we=0, mem_ctrl=1111; next state RDATA.
REQ-022 RDATA: mem_ctrl=0000, mem_we=0, mem_rd=0, so bank outputs hold.
REQ-022a RDATA: when mem_dout_ready=1, SHALL register the extracted result into resp_rdata and go to RESP; otherwise remain in RDATA indefinitely.
REQ-023 Load extraction: LB/LBU SHALL select byte lane addr[1:0]; LH/LHU SHALL select half addr[1]; LW SHALL take the whole word.
REQ-023a LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend.
REQ-024 RESP: resp_valid=1 for exactly one cycle, then IDLE; resp_rdata and resp_err SHALL be stable during RESP.
REQ-025 Outside ACCESS, mem_we, mem_rd and mem_ctrl SHALL be 0.
REQ-025a Outside ACCESS, mem_addr and mem_di SHALL hold their last values (don't-care to memory).
REQ-026 Latency from acceptance edge to resp_valid high: store 2 cycles, load 3 cycles (mem_dout_ready=1), error 1 cycle.
REQ-027 req_valid outside IDLE SHALL be ignored; the requester holds the request until req_ready.
REQ-027a Back-to-back: a request MAY be accepted in the cycle after RESP.

Reset
REQ-028 rst=1 at a clock edge SHALL force state IDLE from any state, aborting in-flight operations without a later resp_valid.
REQ-028a Reset values: req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_rd=0; mem_ctrl=0; mem_addr=0; mem_di=0.
REQ-029 While rst=1, SHALL issue no memory write, including when the previous state was ACCESS.

Verification
REQ-030 SW addr 0x100 wdata 0xDEADBEEF -> ACCESS: mem_we=1, mem_ctrl=1111, mem_addr=0x100, mem_di=0xDEADBEEF; resp_valid 2 cycles after accept, resp_err=0.
REQ-031 SB addr 0x103 wdata 0x000000A5, then LBU and LB 0x103 -> store mem_ctrl=1000, mem_di=0xA5A5A5A5; LBU resp_rdata=0x000000A5, LB resp_rdata=0xFFFFFFA5.
REQ-032 SH addr 0x102 wdata 0x8001, then LH and LHU 0x102 -> store mem_ctrl=1100; LH resp_rdata=0xFFFF8001, LHU resp_rdata=0x00008001.
REQ-033 LW addr 0x101; then LH 0x003; then store funct3 011 -> each: resp_valid 1 cycle after accept, resp_err=1, resp_rdata=0, mem_we/mem_rd/mem_ctrl never asserted.
REQ-034 LW 0x100 with mem_dout_ready held 0 for 3 cycles in RDATA -> stays in RDATA, resp_valid only after ready=1, resp_rdata=0xDEADBEEF.
REQ-035 SW asserted, rst=1 during ACCESS -> next cycle IDLE, req_ready=1, no resp_valid; subsequent LW returns prior memory contents.
